// File: rtl/rr_arb4_16.sv
// rr_arb4_16
// Round-robin arbiter for four requesters (A=0, B=1, C=2, D=3) sharing a
// 16-bit 4:1 datapath mux. A grant is held for a multi-cycle transfer until
// the consumer signals Done, the owner withdraws its request, or a watchdog
// forces release after TIMEOUT cycles. On release the next requester is
// granted on the following cycle with no idle bubble.
//
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous, active-high reset
//   Req     - request lines, bit i = requester i
//   Done    - consumer finished the current transfer (only looked at in BUSY)
//   Gnt     - registered one-hot grant, zero when idle
//   Sel     - registered mux select (00=A .. 11=D), drives the mux Op input
//   Valid   - bus carries granted data this cycle (equals |Gnt)
//   Timeout - one-cycle pulse after the watchdog forces a release

module rr_arb4_16 #(
    parameter int TIMEOUT = 16,
    parameter int CW      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Req,
    input  logic       Done,
    output logic [3:0] Gnt,
    output logic [1:0] Sel,
    output logic       Valid,
    output logic       Timeout
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      gnt_q, gnt_d;
    logic [1:0]      sel_q, sel_d;
    logic [1:0]      last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic            timeout_q, timeout_d;

    logic [1:0]      arb_ptr;
    logic            win_found;
    logic [1:0]      win_idx;
    logic            at_limit;
    logic            release_now;

    // Priority search starts just after arb_ptr and wraps. In BUSY the pointer
    // is the current owner, which both masks it out and still lets it win as
    // the final candidate when it is the only requester left. Because Last is
    // updated to the owner on release, this matches searching from Last+1.
    always_comb begin
        logic [1:0] cand;
        arb_ptr   = (state_q == BUSY) ? sel_q : last_q;
        win_found = 1'b0;
        win_idx   = arb_ptr;
        cand      = arb_ptr;
        for (int k = 1; k <= 4; k++) begin
            cand = arb_ptr + 2'(k);
            if (!win_found && Req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Release conditions for the owner of the current grant. Done, withdrawal
    // and watchdog expiry all collapse into a single release so Last only
    // moves once per transfer.
    always_comb begin
        at_limit    = (cnt_q == CW'(TIMEOUT - 1));
        release_now = Done | ~Req[sel_q] | at_limit;
    end

    // State register: everything, outputs included, resets asynchronously so
    // the grant drops the moment rst rises. Last resets to 3 so requester 0
    // is first in line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= 4'b0000;
            sel_q     <= 2'b00;
            last_q    <= 2'b11;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic: FSM state, round-robin pointer and watchdog counter.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (release_now) begin
                    last_d = sel_q;
                    if (win_found) begin
                        cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: next values of the registered outputs. Sel is left alone
    // whenever nobody is granted so the shared mux output does not toggle.
    // A simultaneous Done suppresses the watchdog pulse.
    always_comb begin
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                gnt_d = 4'b0000;
                if (win_found) begin
                    gnt_d = 4'b0001 << win_idx;
                    sel_d = win_idx;
                end
            end
            BUSY: begin
                if (release_now) begin
                    timeout_d = at_limit & ~Done;
                    gnt_d     = 4'b0000;
                    if (win_found) begin
                        gnt_d = 4'b0001 << win_idx;
                        sel_d = win_idx;
                    end
                end
            end
            default: begin
                gnt_d = 4'b0000;
            end
        endcase
        valid_d = |gnt_d;
    end

    assign Gnt     = gnt_q;
    assign Sel     = sel_q;
    assign Valid   = valid_q;
    assign Timeout = timeout_q;

endmodule

// File: tb/tb_rr_arb4_16.sv
// tb_rr_arb4_16
// Testbench for rr_arb4_16 built with a short watchdog (TIMEOUT=4). Each
// scenario task drives stimulus and compares the DUT outputs, packed as
// {Gnt, Sel, Valid, Timeout}, against fixed values and against a
// transaction-level reference model of the round-robin rules.

module tb_rr_arb4_16;

    localparam int TIMEOUT_P = 4;
    localparam int CW_P      = 8;

    logic       clk;
    logic       rst;
    logic [3:0] Req;
    logic       Done;
    logic [3:0] Gnt;
    logic [1:0] Sel;
    logic       Valid;
    logic       Timeout;

    int checks;
    int errors;

    // Reference model state: who owns the bus, how long it has held it, and
    // which requester was served last.
    bit m_busy;
    int m_cur;
    int m_last;
    int m_cnt;
    bit m_to;

    rr_arb4_16 #(
        .TIMEOUT(TIMEOUT_P),
        .CW     (CW_P)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .Req    (Req),
        .Done   (Done),
        .Gnt    (Gnt),
        .Sel    (Sel),
        .Valid  (Valid),
        .Timeout(Timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // First asserted request counting upward from last+1, or -1 if none.
    function automatic int arb(input logic [3:0] req, input int last);
        int idx;
        for (int k = 1; k <= 4; k++) begin
            idx = (last + k) % 4;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [7:0] model_vec();
        logic [3:0] g;
        logic [1:0] s;
        g = m_busy ? (4'b0001 << m_cur) : 4'b0000;
        s = 2'(m_cur);
        return {g, s, m_busy, m_to};
    endfunction

    function automatic logic [7:0] dut_vec();
        return {Gnt, Sel, Valid, Timeout};
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_cur  = 0;
        m_last = 3;
        m_cnt  = 0;
        m_to   = 1'b0;
    endtask

    // Advance the model by one clock using the inputs the DUT sampled.
    task automatic model_step(input logic [3:0] req, input logic done);
        int w;
        bit rel;
        bit to;
        to = 1'b0;
        if (!m_busy) begin
            w = arb(req, m_last);
            if (w >= 0) begin
                m_busy = 1'b1;
                m_cur  = w;
                m_cnt  = 0;
            end
        end else begin
            rel = done || !req[m_cur] || (m_cnt == TIMEOUT_P - 1);
            to  = !done && (m_cnt == TIMEOUT_P - 1);
            if (rel) begin
                m_last = m_cur;
                w = arb(req, m_cur);
                if (w >= 0) begin
                    m_cur = w;
                    m_cnt = 0;
                end else begin
                    m_busy = 1'b0;
                end
            end else begin
                m_cnt++;
            end
        end
        m_to = to;
    endtask

    // One clock: DUT and model both consume current Req/Done; returns 1 ns
    // after the edge so outputs are settled before anything is compared.
    task automatic step();
        @(posedge clk);
        model_step(Req, Done);
        #1;
    endtask

    task automatic apply_reset();
        Req  = 4'b0000;
        Done = 1'b0;
        rst  = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        Req  = 4'b0000;
        Done = 1'b0;
        rst  = 1'b1;
        model_reset();
        #3;
        checks++;
        if (dut_vec() !== 8'b0000_00_0_0) begin
            errors++;
            $display("[TB] FAIL reset_values: got %b expected %b", dut_vec(), 8'b0000_00_0_0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        apply_reset();
        Req = 4'b0001;
        step();
        checks++;
        if (dut_vec() !== 8'b0001_00_1_0) begin
            errors++;
            $display("[TB] FAIL single_grant: got %b expected %b", dut_vec(), 8'b0001_00_1_0);
        end
        Req  = 4'b0000;
        Done = 1'b1;
        step();
        checks++;
        if (dut_vec() !== 8'b0000_00_0_0) begin
            errors++;
            $display("[TB] FAIL single_release: got %b expected %b", dut_vec(), 8'b0000_00_0_0);
        end
        Done = 1'b0;
    endtask

    task automatic test_rotation();
        logic [3:0] seq [5];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        apply_reset();
        Req  = 4'b1111;
        Done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (Gnt !== seq[i] || Valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rotation_%0d: got Gnt=%b Valid=%b expected Gnt=%b Valid=1",
                         i, Gnt, Valid, seq[i]);
            end
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("[TB] FAIL rotation_model_%0d: got %b expected %b", i, dut_vec(), model_vec());
            end
        end
        Done = 1'b0;
    endtask

    task automatic test_skip_owner();
        apply_reset();
        Req = 4'b0100;
        step();
        checks++;
        if (dut_vec() !== 8'b0100_10_1_0) begin
            errors++;
            $display("[TB] FAIL skip_first: got %b expected %b", dut_vec(), 8'b0100_10_1_0);
        end
        Req  = 4'b1011;
        Done = 1'b1;
        step();
        checks++;
        if (dut_vec() !== 8'b1000_11_1_0) begin
            errors++;
            $display("[TB] FAIL skip_next: got %b expected %b", dut_vec(), 8'b1000_11_1_0);
        end
        Done = 1'b0;
    endtask

    task automatic test_timeout();
        logic [5:0] to_seq;
        to_seq = 6'b010000;
        apply_reset();
        Req  = 4'b0100;
        Done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (dut_vec() !== {4'b0100, 2'b10, 1'b1, to_seq[i]}) begin
                errors++;
                $display("[TB] FAIL timeout_%0d: got %b expected %b",
                         i, dut_vec(), {4'b0100, 2'b10, 1'b1, to_seq[i]});
            end
        end
    endtask

    task automatic test_withdraw();
        apply_reset();
        Req = 4'b0010;
        step();
        step();
        checks++;
        if (dut_vec() !== 8'b0010_01_1_0) begin
            errors++;
            $display("[TB] FAIL withdraw_hold: got %b expected %b", dut_vec(), 8'b0010_01_1_0);
        end
        Req = 4'b0000;
        step();
        checks++;
        if (dut_vec() !== 8'b0000_01_0_0) begin
            errors++;
            $display("[TB] FAIL withdraw_drop: got %b expected %b", dut_vec(), 8'b0000_01_0_0);
        end
        Req = 4'b0011;
        step();
        checks++;
        if (dut_vec() !== 8'b0001_00_1_0) begin
            errors++;
            $display("[TB] FAIL withdraw_regrant: got %b expected %b", dut_vec(), 8'b0001_00_1_0);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        Req = 4'b1000;
        step();
        checks++;
        if (dut_vec() !== 8'b1000_11_1_0) begin
            errors++;
            $display("[TB] FAIL async_pre: got %b expected %b", dut_vec(), 8'b1000_11_1_0);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== 8'b0000_00_0_0) begin
            errors++;
            $display("[TB] FAIL async_drop: got %b expected %b", dut_vec(), 8'b0000_00_0_0);
        end
        #2;
        rst = 1'b0;
        Req = 4'b1001;
        step();
        checks++;
        if (dut_vec() !== 8'b0001_00_1_0) begin
            errors++;
            $display("[TB] FAIL async_after: got %b expected %b", dut_vec(), 8'b0001_00_1_0);
        end
    endtask

    task automatic test_random();
        logic [3:0] g;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) Req = 4'($urandom_range(0, 15));
            Done = ($urandom_range(0, 3) == 0);
            step();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("[TB] FAIL random_%0d: got %b expected %b (Req=%b Done=%b)",
                         i, dut_vec(), model_vec(), Req, Done);
            end
            g = Gnt;
            checks++;
            if (($countones(g) > 1) || (Valid && (g !== (4'b0001 << Sel)))) begin
                errors++;
                $display("[TB] FAIL invariant_%0d: got Gnt=%b Sel=%b Valid=%b expected one-hot Gnt matching Sel",
                         i, g, Sel, Valid);
            end
        end
        Done = 1'b0;
        Req  = 4'b0000;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        Req    = 4'b0000;
        Done   = 1'b0;
        model_reset();
        #1;
        test_reset();
        test_single();
        test_rotation();
        test_skip_owner();
        test_timeout();
        test_withdraw();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
